mem_line_backend: RTL and testbench



---
 rtl/mem_line_backend_if.sv | 15 +
 rtl/mem_line_backend.sv | 126 ++++++++++++
 tb/tb_mem_line_backend.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_backend_if.sv
// Core-to-memory line request bundle: read/write strobes, line address and line data.
interface MEM_core_request_if #(
   parameter int unsigned PHYSICAL_ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH          = 128
);
   localparam int unsigned LineAddrWidth = PHYSICAL_ADDR_WIDTH - $clog2(LINE_WIDTH / 8);

   logic                     read;
   logic                     write;
   logic [LineAddrWidth-1:0] line_addr;
   logic [LINE_WIDTH-1:0]    line_data;

   modport master (output read, output write, output line_addr, output line_data);
   modport slave  (input  read, input  write, input  line_addr, input  line_data);
endinterface

// File: rtl/mem_line_backend.sv
// Line-wide main-memory backend: one outstanding request, response after LATENCY cycles.
// Optional MEM_WRITE_ACK_EN: writes also pulse resp_valid, returning the written line.
module mem_line_backend #(
   parameter int unsigned LATENCY             = 4,
   parameter int unsigned DEPTH_LINES         = 1024,
   parameter int unsigned PHYSICAL_ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH          = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   MEM_core_request_if.slave     req,
   output logic                  busy,
   output logic                  resp_valid,
   output logic [LINE_WIDTH-1:0] resp_data
);
   localparam int unsigned LineAddrWidth = PHYSICAL_ADDR_WIDTH - $clog2(LINE_WIDTH / 8);
   localparam int unsigned IdxWidth      = $clog2(DEPTH_LINES);
   localparam logic [7:0]  CntInit       = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  rd_q, wr_q;
   logic [IdxWidth-1:0]   idx_q;
   logic [LINE_WIDTH-1:0] data_q;
   logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

   logic                  accept;
   logic                  enter_done;
   logic                  acc_rd, acc_wr;
   logic [IdxWidth-1:0]   acc_idx;
   logic [LINE_WIDTH-1:0] acc_data;
   logic                  unused_addr;

   // Upper line-address bits alias onto the same storage lines.
   assign unused_addr = ^req.line_addr[LineAddrWidth-1:IdxWidth];

   assign accept = (state_q != StWait) && (req.read || req.write);

   // With LATENCY=1 the access happens on the accepting edge, so use the live request.
   assign acc_rd     = (state_q == StWait) ? rd_q   : req.read;
   assign acc_wr     = (state_q == StWait) ? wr_q   : req.write;
   assign acc_idx    = (state_q == StWait) ? idx_q  : req.line_addr[IdxWidth-1:0];
   assign acc_data   = (state_q == StWait) ? data_q : req.line_data;
   assign enter_done = rst_n && (state_d == StDone);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StWait: begin
            if (cnt_q == 8'd0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            if (accept) begin
               state_d = (LATENCY == 1) ? StDone : StWait;
               cnt_d   = CntInit;
            end else begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_comb begin
      busy       = (state_q == StWait);
      resp_valid = 1'b0;
      if (state_q == StDone) begin
`ifdef MEM_WRITE_ACK_EN
         resp_valid = rd_q | wr_q;
`else
         resp_valid = rd_q & ~wr_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         resp_data <= '0;
      end else begin
         if (accept) begin
            rd_q   <= req.read;
            wr_q   <= req.write;
            idx_q  <= req.line_addr[IdxWidth-1:0];
            data_q <= req.line_data;
         end
         // A simultaneous read+write is serviced as a write only.
         if (enter_done) begin
            if (acc_rd && !acc_wr) begin
               resp_data <= mem[acc_idx];
            end
`ifdef MEM_WRITE_ACK_EN
            else if (acc_wr) begin
               resp_data <= acc_data;
            end
`endif
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (enter_done && acc_wr) begin
         mem[acc_idx] <= acc_data;
      end
   end
endmodule

// File: tb/tb_mem_line_backend.sv
// Self-checking bench for mem_line_backend: directed scenarios plus randomized traffic
// against a line-array reference model; a second instance covers LATENCY=1.
module tb_mem_line_backend;
   localparam int Lat   = 4;
   localparam int Depth = 1024;
   localparam int PaW   = 32;
   localparam int LineW = 128;
   localparam int LaW   = PaW - 4;
`ifdef MEM_WRITE_ACK_EN
   localparam bit WriteAck = 1'b1;
`else
   localparam bit WriteAck = 1'b0;
`endif

   typedef struct packed {
      logic             rd;
      logic             wr;
      logic [LaW-1:0]   addr;
      logic [LineW-1:0] data;
   } txn_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             busy, resp_valid, busy1, resp_valid1;
   logic [LineW-1:0] resp_data, resp_data1;

   logic [LineW-1:0] model_mem  [Depth];
   logic [LineW-1:0] model1_mem [Depth];
   logic [LineW-1:0] exp_data, exp1_data;
   int               n_pass, n_checks;

   always #5 clk = ~clk;

   MEM_core_request_if #(.PHYSICAL_ADDR_WIDTH(PaW), .LINE_WIDTH(LineW)) req_if ();
   MEM_core_request_if #(.PHYSICAL_ADDR_WIDTH(PaW), .LINE_WIDTH(LineW)) req1_if ();

   mem_line_backend #(
      .LATENCY(Lat), .DEPTH_LINES(Depth), .PHYSICAL_ADDR_WIDTH(PaW), .LINE_WIDTH(LineW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req_if), .busy(busy), .resp_valid(resp_valid),
      .resp_data(resp_data)
   );

   mem_line_backend #(
      .LATENCY(1), .DEPTH_LINES(Depth), .PHYSICAL_ADDR_WIDTH(PaW), .LINE_WIDTH(LineW)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1_if), .busy(busy1), .resp_valid(resp_valid1),
      .resp_data(resp_data1)
   );

   function automatic txn_t mk(input bit rd, input bit wr, input logic [LaW-1:0] addr,
                               input logic [LineW-1:0] data);
      txn_t t;
      t.rd = rd; t.wr = wr; t.addr = addr; t.data = data;
      return t;
   endfunction

   // Spec-level model: writes win over reads, index is the address modulo the depth.
   function automatic void model_apply(input int unit, input txn_t t, output bit vld,
                                       output logic [LineW-1:0] resp);
      int idx;
      idx  = int'(t.addr) % Depth;
      vld  = 1'b0;
      resp = '0;
      if (t.wr) begin
         if (unit == 0) model_mem[idx] = t.data;
         else           model1_mem[idx] = t.data;
         vld  = WriteAck;
         resp = t.data;
      end else if (t.rd) begin
         vld  = 1'b1;
         resp = (unit == 0) ? model_mem[idx] : model1_mem[idx];
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input txn_t t);
      req_if.read = t.rd; req_if.write = t.wr;
      req_if.line_addr = t.addr; req_if.line_data = t.data;
   endtask

   task automatic drive1(input txn_t t);
      req1_if.read = t.rd; req1_if.write = t.wr;
      req1_if.line_addr = t.addr; req1_if.line_data = t.data;
   endtask

   function automatic logic [LineW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      drive(mk(1'b0, 1'b1, 28'h5, {4{32'hBAD0_BAD0}}));
      drive1(mk(1'b0, 1'b1, 28'h5, {4{32'hBAD1_BAD1}}));
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({busy, resp_valid, resp_data, busy1, resp_valid1, resp_data1} !== '0)
            $display("FAIL reset cycle %0d: got busy=%b/%b valid=%b/%b data=%h/%h, required all 0",
                     i, busy, busy1, resp_valid, resp_valid1, resp_data, resp_data1);
         else n_pass++;
      end
      drive(mk(0, 0, '0, '0));
      drive1(mk(0, 0, '0, '0));
      rst_n = 1'b1;
   endtask

   task automatic test_read_latency();
      txn_t t;
      bit vld, eb, ev;
      logic [LineW-1:0] pend;
      t = mk(1'b1, 1'b0, 28'h5, '0);
      model_apply(0, t, vld, pend);
      drive(t); tick(); drive(mk(0, 0, '0, '0));
      for (int i = 1; i <= Lat; i++) begin
         if (i == Lat && vld) exp_data = pend;
         eb = (i < Lat); ev = vld && (i == Lat);
         n_checks++;
         if ({busy, resp_valid, resp_data} !== {eb, ev, exp_data})
            $display("FAIL read_latency cycle %0d: got busy=%b valid=%b data=%h, required %b %b %h",
                     i, busy, resp_valid, resp_data, eb, ev, exp_data);
         else n_pass++;
         if (i < Lat) tick();
      end
      tick();
      n_checks++;
      if ({busy, resp_valid, resp_data} !== {1'b0, 1'b0, exp_data})
         $display("FAIL read_latency idle: got busy=%b valid=%b data=%h, required 0 0 %h",
                  busy, resp_valid, resp_data, exp_data);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      txn_t seq[2];
      bit vld, eb, ev;
      logic [LineW-1:0] pend;
      seq[0] = mk(1'b0, 1'b1, 28'h12, {4{32'hDEAD_BEEF}});
      seq[1] = mk(1'b1, 1'b0, 28'h12, '0);
      for (int k = 0; k < 2; k++) begin
         model_apply(0, seq[k], vld, pend);
         drive(seq[k]); tick(); drive(mk(0, 0, '0, '0));
         for (int i = 1; i <= Lat; i++) begin
            if (i == Lat && vld) exp_data = pend;
            eb = (i < Lat); ev = vld && (i == Lat);
            n_checks++;
            if ({busy, resp_valid, resp_data} !== {eb, ev, exp_data})
               $display("FAIL back_to_back txn %0d cycle %0d: got %b %b %h, required %b %b %h",
                        k, i, busy, resp_valid, resp_data, eb, ev, exp_data);
            else n_pass++;
            if (i < Lat) tick();
         end
      end
   endtask

   task automatic test_busy_ignore();
      txn_t t;
      bit vld, eb, ev;
      logic [LineW-1:0] pend;
      t = mk(1'b1, 1'b0, 28'h12, '0);
      model_apply(0, t, vld, pend);
      drive(t); tick();
      for (int i = 1; i <= Lat; i++) begin
         drive((i < Lat) ? mk(1'b1, 1'b0, 28'h7, '0) : mk(0, 0, '0, '0));
         if (i == Lat && vld) exp_data = pend;
         eb = (i < Lat); ev = vld && (i == Lat);
         n_checks++;
         if ({busy, resp_valid, resp_data} !== {eb, ev, exp_data})
            $display("FAIL busy_ignore cycle %0d: got %b %b %h, required %b %b %h",
                     i, busy, resp_valid, resp_data, eb, ev, exp_data);
         else n_pass++;
         if (i < Lat) tick();
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({busy, resp_valid, resp_data} !== {1'b0, 1'b0, exp_data})
            $display("FAIL busy_ignore tail %0d: got %b %b %h, required 0 0 %h",
                     i, busy, resp_valid, resp_data, exp_data);
         else n_pass++;
      end
   endtask

   task automatic test_read_write_both();
      txn_t seq[2];
      bit vld, eb, ev;
      logic [LineW-1:0] pend;
      seq[0] = mk(1'b1, 1'b1, 28'h3, 128'hA5);
      seq[1] = mk(1'b1, 1'b0, 28'h3, '0);
      for (int k = 0; k < 2; k++) begin
         model_apply(0, seq[k], vld, pend);
         drive(seq[k]); tick(); drive(mk(0, 0, '0, '0));
         for (int i = 1; i <= Lat; i++) begin
            if (i == Lat && vld) exp_data = pend;
            eb = (i < Lat); ev = vld && (i == Lat);
            n_checks++;
            if ({busy, resp_valid, resp_data} !== {eb, ev, exp_data})
               $display("FAIL rw_both txn %0d cycle %0d: got %b %b %h, required %b %b %h",
                        k, i, busy, resp_valid, resp_data, eb, ev, exp_data);
            else n_pass++;
            if (i < Lat) tick();
         end
      end
   endtask

   task automatic test_reset_mid();
      txn_t t;
      bit vld, eb, ev;
      logic [LineW-1:0] pend;
      // This write is discarded by reset, so the model is not updated.
      drive(mk(1'b0, 1'b1, 28'h9, {4{32'h1234_5678}})); tick(); drive(mk(0, 0, '0, '0));
      n_checks++;
      if (busy !== 1'b1) $display("FAIL reset_mid busy: got %b, required 1", busy);
      else n_pass++;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      exp_data = '0; exp1_data = '0;
      for (int i = 0; i < Lat; i++) begin
         n_checks++;
         if ({busy, resp_valid, resp_data} !== {1'b0, 1'b0, exp_data})
            $display("FAIL reset_mid quiet %0d: got %b %b %h, required 0 0 %h",
                     i, busy, resp_valid, resp_data, exp_data);
         else n_pass++;
         tick();
      end
      t = mk(1'b1, 1'b0, 28'h9, '0);
      model_apply(0, t, vld, pend);
      drive(t); tick(); drive(mk(0, 0, '0, '0));
      for (int i = 1; i <= Lat; i++) begin
         if (i == Lat && vld) exp_data = pend;
         eb = (i < Lat); ev = vld && (i == Lat);
         n_checks++;
         if ({busy, resp_valid, resp_data} !== {eb, ev, exp_data})
            $display("FAIL reset_mid read cycle %0d: got %b %b %h, required %b %b %h",
                     i, busy, resp_valid, resp_data, eb, ev, exp_data);
         else n_pass++;
         if (i < Lat) tick();
      end
   endtask

   task automatic test_latency1();
      txn_t seq[6];
      bit vld;
      logic [LineW-1:0] pend;
      seq[0] = mk(1'b0, 1'b1, 28'h4, rnd_line());
      seq[1] = mk(1'b1, 1'b0, 28'h4, '0);
      seq[2] = mk(1'b1, 1'b0, 28'h5, '0);
      seq[3] = mk(1'b1, 1'b1, 28'h6, rnd_line());
      seq[4] = mk(1'b1, 1'b0, 28'h6, '0);
      seq[5] = mk(1'b1, 1'b0, 28'h404, '0);
      for (int k = 0; k < 6; k++) begin
         model_apply(1, seq[k], vld, pend);
         drive1(seq[k]); tick(); drive1(mk(0, 0, '0, '0));
         if (vld) exp1_data = pend;
         n_checks++;
         if ({busy1, resp_valid1, resp_data1} !== {1'b0, vld, exp1_data})
            $display("FAIL latency1 txn %0d: got busy=%b valid=%b data=%h, required 0 %b %h",
                     k, busy1, resp_valid1, resp_data1, vld, exp1_data);
         else n_pass++;
      end
      tick();
      n_checks++;
      if ({busy1, resp_valid1, resp_data1} !== {1'b0, 1'b0, exp1_data})
         $display("FAIL latency1 idle: got %b %b %h, required 0 0 %h",
                  busy1, resp_valid1, resp_data1, exp1_data);
      else n_pass++;
   endtask

   task automatic test_alias();
      txn_t seq[2];
      bit vld, eb, ev;
      logic [LineW-1:0] pend, wdata;
      wdata  = rnd_line();
      seq[0] = mk(1'b0, 1'b1, 28'h405, wdata);
      seq[1] = mk(1'b1, 1'b0, 28'h005, '0);
      for (int k = 0; k < 2; k++) begin
         model_apply(0, seq[k], vld, pend);
         drive(seq[k]); tick(); drive(mk(0, 0, '0, '0));
         for (int i = 1; i <= Lat; i++) begin
            if (i == Lat && vld) exp_data = pend;
            eb = (i < Lat); ev = vld && (i == Lat);
            n_checks++;
            if ({busy, resp_valid, resp_data} !== {eb, ev, exp_data})
               $display("FAIL alias txn %0d cycle %0d: got %b %b %h, required %b %b %h",
                        k, i, busy, resp_valid, resp_data, eb, ev, exp_data);
            else n_pass++;
            if (i < Lat) tick();
         end
      end
      n_checks++;
      if (resp_data !== wdata)
         $display("FAIL alias data: got %h, required %h", resp_data, wdata);
      else n_pass++;
   endtask

   task automatic test_random();
      txn_t t;
      bit vld, eb, ev;
      int op;
      logic [LineW-1:0] pend;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            drive(mk(0, 0, '0, '0)); tick();
            n_checks++;
            if ({busy, resp_valid, resp_data} !== {1'b0, 1'b0, exp_data})
               $display("FAIL random gap %0d: got %b %b %h, required 0 0 %h",
                        k, busy, resp_valid, resp_data, exp_data);
            else n_pass++;
         end
         op = $urandom_range(0, 3);
         t  = mk(op != 1, op == 1 || op == 2,
                 {18'($urandom), 10'($urandom_range(0, 31))}, rnd_line());
         model_apply(0, t, vld, pend);
         drive(t); tick();
         for (int i = 1; i <= Lat; i++) begin
            if (i < Lat && $urandom_range(0, 1) == 1)
               drive(mk(1'($urandom), 1'($urandom), 28'($urandom), rnd_line()));
            else
               drive(mk(0, 0, '0, '0));
            if (i == Lat && vld) exp_data = pend;
            eb = (i < Lat); ev = vld && (i == Lat);
            n_checks++;
            if ({busy, resp_valid, resp_data} !== {eb, ev, exp_data})
               $display("FAIL random txn %0d cycle %0d: got %b %b %h, required %b %b %h",
                        k, i, busy, resp_valid, resp_data, eb, ev, exp_data);
            else n_pass++;
            if (i < Lat) tick();
         end
      end
      drive(mk(0, 0, '0, '0));
   endtask

   initial begin
      n_pass = 0; n_checks = 0;
      exp_data = '0; exp1_data = '0;
      for (int i = 0; i < Depth; i++) begin
         model_mem[i]  = '0;
         model1_mem[i] = '0;
      end
      rst_n = 1'b0;
      drive(mk(0, 0, '0, '0));
      drive1(mk(0, 0, '0, '0));
      #1;
      test_reset();
      test_read_latency();
      test_back_to_back();
      test_busy_ignore();
      test_read_write_both();
      test_reset_mid();
      test_latency1();
      test_alias();
      test_random();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
